output_neuron_seq: RTL and testbench

- Sequential output-layer neuron that consumes the four hidden-layer results over the hidden layer's `output_ready` handshake.
- Registers the four signed hidden outputs on the ready pulse, then performs a 4-cycle serial multiply-accumulate against static 5-bit weights.
- Applies optional ReLU and saturation, and presents the result with a one-cycle `result_ready` pulse.
- Time-multiplexes a single multiplier instead of using four parallel ones.

---
 rtl/output_neuron_seq.sv | 164 ++++++++++++++++
 tb/tb_output_neuron_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/output_neuron_seq.sv
// Sequential output-layer neuron.
// Captures four signed hidden-layer outputs on an input_ready strobe. It then
// runs a 4-cycle serial multiply-accumulate against static 5-bit weights,
// using one shared multiplier. Optional ReLU and saturation are applied next,
// and the result is presented with a one-cycle result_ready pulse.
// Ports:
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   input_ready         : strobe, in0..in3 valid in this cycle
//   in0..in3            : signed hidden-layer outputs (input_width)
//   w0..w3              : signed static weights (5 bits)
//   result              : registered signed neuron output (output_width)
//   result_ready        : one-cycle pulse, result valid in same cycle
//   busy                : MAC sequence in progress
//   overrun             : sticky, strobe arrived while busy
module output_neuron_seq #(
  parameter int unsigned input_width  = 12,
  parameter int unsigned output_width = 16,
  parameter int unsigned RELU         = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           input_ready,
  input  logic signed [input_width-1:0]  in0,
  input  logic signed [input_width-1:0]  in1,
  input  logic signed [input_width-1:0]  in2,
  input  logic signed [input_width-1:0]  in3,
  input  logic signed [4:0]              w0,
  input  logic signed [4:0]              w1,
  input  logic signed [4:0]              w2,
  input  logic signed [4:0]              w3,
  output logic signed [output_width-1:0] result,
  output logic                           result_ready,
  output logic                           busy,
  output logic                           overrun
);

  localparam int unsigned PROD_W = input_width + 5;
  localparam int unsigned ACC_W  = input_width + 7;
  // Compare width wide enough for both the accumulator and the clamp limits
  localparam int unsigned CMP_W  = (ACC_W > output_width) ? ACC_W : output_width;

  localparam logic signed [CMP_W-1:0] SAT_MAX =
    {{(CMP_W-output_width+1){1'b0}}, {(output_width-1){1'b1}}};
  localparam logic signed [CMP_W-1:0] SAT_MIN =
    {{(CMP_W-output_width+1){1'b1}}, {(output_width-1){1'b0}}};

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MAC = 1'b1} state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic        [1:0]               r_idx;
  logic signed [input_width-1:0]   r_x [4];
  logic signed [ACC_W-1:0]         r_acc;
  logic signed [output_width-1:0]  r_result;
  logic                            r_result_ready;
  logic                            r_busy;
  logic                            r_overrun;

  logic                            w_load;
  logic                            w_mac;
  logic                            w_done;
  logic signed [input_width-1:0]   w_x_sel;
  logic signed [4:0]               w_w_sel;
  logic signed [PROD_W-1:0]        w_prod;
  logic signed [ACC_W-1:0]         w_sum;
  logic signed [CMP_W-1:0]         w_sum_ext;
  logic signed [CMP_W-1:0]         w_relu;
  logic signed [output_width-1:0]  w_sat;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (input_ready) w_state_nxt = S_MAC;
      S_MAC:   if (r_idx == 2'd3) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM control outputs
  always_comb begin
    w_load = 1'b0;
    w_mac  = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: w_load = input_ready;
      S_MAC: begin
        w_mac  = 1'b1;
        w_done = (r_idx == 2'd3);
      end
      default: ;
    endcase
  end

  // Operand select for the shared multiplier
  always_comb begin
    w_x_sel = r_x[0];
    w_w_sel = w0;
    case (r_idx)
      2'd1: begin w_x_sel = r_x[1]; w_w_sel = w1; end
      2'd2: begin w_x_sel = r_x[2]; w_w_sel = w2; end
      2'd3: begin w_x_sel = r_x[3]; w_w_sel = w3; end
      default: ;
    endcase
  end

  // Multiply-accumulate, then ReLU ahead of the clamp
  always_comb begin
    w_prod    = PROD_W'(w_x_sel) * PROD_W'(w_w_sel);
    w_sum     = r_acc + ACC_W'(w_prod);
    w_sum_ext = CMP_W'(w_sum);
    w_relu    = ((RELU != 0) && w_sum[ACC_W-1]) ? '0 : w_sum_ext;
    if (w_relu > SAT_MAX)      w_sat = output_width'(SAT_MAX);
    else if (w_relu < SAT_MIN) w_sat = output_width'(SAT_MIN);
    else                       w_sat = output_width'(w_relu);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx          <= 2'd0;
      r_acc          <= '0;
      r_result       <= '0;
      r_result_ready <= 1'b0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
      for (int i = 0; i < 4; i++) r_x[i] <= '0;
    end else begin
      r_result_ready <= 1'b0;
      if (w_load) begin
        r_x[0] <= in0;
        r_x[1] <= in1;
        r_x[2] <= in2;
        r_x[3] <= in3;
        r_acc  <= '0;
        r_idx  <= 2'd0;
        r_busy <= 1'b1;
      end
      if (w_mac) begin
        r_acc <= w_sum;
        r_idx <= r_idx + 2'd1;
      end
      // Final term goes straight into the result register
      if (w_done) begin
        r_result       <= w_sat;
        r_result_ready <= 1'b1;
        r_busy         <= 1'b0;
      end
      if (input_ready && r_busy) r_overrun <= 1'b1;
    end
  end

  assign result       = r_result;
  assign result_ready = r_result_ready;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_output_neuron_seq.sv
// Directed bench for output_neuron_seq; two instances share stimulus,
// one with RELU=0 and one with RELU=1.
module tb_output_neuron_seq;

  logic               clk = 1'b0;
  logic               rst;
  logic               input_ready;
  logic signed [11:0] in0, in1, in2, in3;
  logic signed [4:0]  w0, w1, w2, w3;
  logic signed [15:0] result, result_r;
  logic               result_ready, result_ready_r;
  logic               busy, busy_r;
  logic               overrun, overrun_r;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  output_neuron_seq #(.input_width(12), .output_width(16), .RELU(0)) dut (
    .clk(clk), .rst(rst), .input_ready(input_ready),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3),
    .result(result), .result_ready(result_ready),
    .busy(busy), .overrun(overrun)
  );

  output_neuron_seq #(.input_width(12), .output_width(16), .RELU(1)) dut_r (
    .clk(clk), .rst(rst), .input_ready(input_ready),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3),
    .result(result_r), .result_ready(result_ready_r),
    .busy(busy_r), .overrun(overrun_r)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int a, input int b, input int c, input int d);
    w0 = 5'(a); w1 = 5'(b); w2 = 5'(c); w3 = 5'(d);
  endtask

  // Strobe in the current cycle (cycle 0); returns in cycle 1
  task automatic strobe(input int a, input int b, input int c, input int d);
    in0 = 12'(a); in1 = 12'(b); in2 = 12'(c); in3 = 12'(d);
    input_ready = 1'b1;
    tick();
    input_ready = 1'b0;
  endtask

  // From cycle 1, check MAC cycles 1-4 then the result in cycle 5
  task automatic finish_seq(input string tag, input int exp0, input int exp1);
    for (int k = 1; k <= 4; k++) begin
      chk({tag, "_busy"}, 32'(busy), 1);
      chk({tag, "_rr_early"}, 32'(result_ready), 0);
      if (k < 4) tick();
    end
    tick();
    chk({tag, "_rr"}, 32'(result_ready), 1);
    chk({tag, "_rr_relu"}, 32'(result_ready_r), 1);
    chk({tag, "_result"}, 32'(result), exp0);
    chk({tag, "_result_relu"}, 32'(result_r), exp1);
    chk({tag, "_busy_done"}, 32'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; input_ready = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    set_w(1, 1, 1, 1);
    tick(); tick();
    rst = 1'b0;
    chk("reset_result", 32'(result), 0);
    chk("reset_rr", 32'(result_ready), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_overrun", 32'(overrun), 0);
    tick();

    // Basic MAC
    strobe(1, 2, 3, 4);
    finish_seq("basic", 10, 10);
    tick();
    chk("basic_rr_clear", 32'(result_ready), 0);
    chk("basic_hold", 32'(result), 10);

    // Signed mix
    set_w(3, -2, -16, 15);
    strobe(100, -50, 7, -1);
    finish_seq("signed_mix", 273, 273);
    tick();

    // Positive saturation
    set_w(15, 15, 15, 15);
    strobe(2047, 2047, 2047, 2047);
    finish_seq("sat_pos", 32767, 32767);
    tick();

    // Negative clamp, and ReLU forcing zero
    strobe(-2048, -2048, -2048, -2048);
    finish_seq("sat_neg", -32768, 0);
    tick();

    // Overrun: second strobe in cycle 2 is ignored
    set_w(1, 1, 1, 1);
    strobe(1, 2, 3, 4);
    tick();
    in0 = 12'sd9; in1 = 12'sd9; in2 = 12'sd9; in3 = 12'sd9;
    input_ready = 1'b1;
    tick();
    input_ready = 1'b0;
    chk("ovr_set", 32'(overrun), 1);
    chk("ovr_busy", 32'(busy), 1);
    tick(); tick();
    chk("ovr_rr", 32'(result_ready), 1);
    chk("ovr_result", 32'(result), 10);
    tick();
    strobe(2, 2, 2, 2);
    finish_seq("ovr_next", 8, 8);
    chk("ovr_sticky", 32'(overrun), 1);

    // Clear overrun with reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_clears_ovr", 32'(overrun), 0);
    tick();

    // Back-to-back: second strobe in cycle 5
    strobe(1, 2, 3, 4);
    finish_seq("b2b_first", 10, 10);
    strobe(5, 5, 5, 5);
    finish_seq("b2b_second", 20, 20);
    chk("b2b_no_overrun", 32'(overrun), 0);
    tick();

    // Reset mid-operation (overrun set first so the clear is visible)
    strobe(1, 2, 3, 4);
    tick();
    input_ready = 1'b1;
    tick();
    input_ready = 1'b0;
    chk("rstmid_ovr_pre", 32'(overrun), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_result", 32'(result), 0);
    chk("rstmid_overrun", 32'(overrun), 0);
    chk("rstmid_rr4", 32'(result_ready), 0);
    tick();
    chk("rstmid_rr5", 32'(result_ready), 0);
    tick();
    set_w(1, -1, 1, -1);
    strobe(4, 3, 2, 1);
    finish_seq("rstmid_new", 2, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
